// File: rtl/sobel_stream_gradient_pkg.sv
// Shared types and helpers for the Canny gradient stage.
// Direction codes, FSM states and the direction threshold ratio.
package canny_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } grad_dir_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sobel_state_t;

    // tan(22.5deg) ~= TAN_NUM / TAN_DEN
    localparam int TAN_NUM = 2;
    localparam int TAN_DEN = 5;

    function automatic logic [31:0] sobel_abs(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

endpackage

// File: rtl/sobel_stream_gradient_if.sv
// Pixel-in / gradient-out stream bundle for the Sobel stage.
// slave is the stage's view, master the upstream/downstream view.
interface sobel_stream_gradient_if #(
    parameter int DW = 8
);
    import canny_pkg::*;

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_mag;
    grad_dir_t     m_dir;
    logic          m_sof;
    logic          m_eof;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_mag, m_dir, m_sof, m_eof
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_mag, m_dir, m_sof, m_eof
    );

endinterface

// File: rtl/sobel_stream_gradient_line_buffer.sv
// Two row delay lines plus window taps; the bottom-right tap is the
// incoming pixel so a window is ready on the same beat it completes.
module sobel_line_buffer #(
    parameter int DW    = 8,
    parameter int IMG_W = 200
) (
    input  logic                    clk,
    input  logic                    shift,
    input  logic [DW-1:0]           din,
    output logic [2:0][2:0][DW-1:0] win
);
    localparam int D = 2 * IMG_W + 2;

    // hist[k] holds the pixel accepted k+1 shifts ago
    logic [D-1:0][DW-1:0] hist;

    always_ff @(posedge clk) begin
        if (shift) begin
            hist <= {hist[D-2:0], din};
        end
    end

    always_comb begin
        win[2][2] = din;
        win[2][1] = hist[0];
        win[2][0] = hist[1];
        win[1][2] = hist[IMG_W-1];
        win[1][1] = hist[IMG_W];
        win[1][0] = hist[IMG_W+1];
        win[0][2] = hist[2*IMG_W-1];
        win[0][1] = hist[2*IMG_W];
        win[0][0] = hist[2*IMG_W+1];
    end

endmodule

// File: rtl/sobel_stream_gradient.sv
// Streaming 3x3 Sobel gradient: line-buffered window, L1 magnitude and
// quantised direction, one output register with valid/ready.
module sobel_stream_gradient
    import canny_pkg::*;
#(
    parameter int DW        = 8,
    parameter int IMG_W     = 200,
    parameter int IMG_H     = 200,
    parameter int MAG_SHIFT = 3
) (
    input logic                    clk,
    input logic                    reset,
    sobel_stream_gradient_if.slave bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int GW   = DW + 3;
    localparam int TW   = GW + 3;

    sobel_state_t state, state_nx;

    logic                    armed;
    logic                    accept;
    logic                    load;
    logic                    shift;
    logic                    border;
    logic                    first;
    logic                    last;
    logic [PW-1:0]           pix_cnt;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DW-1:0]           din;
    logic [DW-1:0]           mag;
    logic [2:0][2:0][DW-1:0] win;
    logic [DW+1:0]           xr, xl, yt, yb;
    logic signed [GW-1:0]    gx, gy;
    logic [GW-1:0]           ax, ay;
    logic [GW:0]             sum, sh;
    logic [TW-1:0]           ax_n, ay_n, ax_d, ay_d;
    grad_dir_t               dir;

    function automatic logic [DW+1:0] col3(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] c
    );
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // armed keeps s_ready low while reset is held
    assign bus.s_ready = armed && (state != FLUSH)
                       && (!bus.m_valid || bus.m_ready);
    assign accept = bus.s_valid && bus.s_ready;
    assign din    = (state == FLUSH) ? '0 : bus.s_data;

    sobel_line_buffer #(
        .DW    (DW),
        .IMG_W (IMG_W)
    ) u_lb (
        .clk   (clk),
        .shift (shift),
        .din   (din),
        .win   (win)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state)
            FILL: begin
                shift = accept;
                if (accept && pix_cnt == PW'(IMG_W)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                shift = accept;
                load  = accept;
                if (accept && pix_cnt == PW'(NPIX - 1)) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                load  = !(bus.m_valid && (bus.m_eof || !bus.m_ready));
                shift = load;
                if (bus.m_valid && bus.m_ready && bus.m_eof) begin
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_comb begin
        xr   = col3(win[0][2], win[1][2], win[2][2]);
        xl   = col3(win[0][0], win[1][0], win[2][0]);
        yt   = col3(win[0][0], win[0][1], win[0][2]);
        yb   = col3(win[2][0], win[2][1], win[2][2]);
        gx   = $signed({1'b0, xr}) - $signed({1'b0, xl});
        gy   = $signed({1'b0, yt}) - $signed({1'b0, yb});
        ax   = GW'(sobel_abs(32'(gx)));
        ay   = GW'(sobel_abs(32'(gy)));
        sum  = {1'b0, ax} + {1'b0, ay};
        sh   = sum >> MAG_SHIFT;
        mag  = (|sh[GW:DW]) ? '1 : sh[DW-1:0];
        ax_n = TW'(ax) * TW'(TAN_NUM);
        ay_n = TW'(ay) * TW'(TAN_NUM);
        ax_d = TW'(ax) * TW'(TAN_DEN);
        ay_d = TW'(ay) * TW'(TAN_DEN);
        if (ay_d < ax_n || (ax == '0 && ay == '0)) begin
            dir = DIR_0;
        end else if (ax_d < ay_n) begin
            dir = DIR_90;
        end else if (gx[GW-1] == gy[GW-1]) begin
            dir = DIR_45;
        end else begin
            dir = DIR_135;
        end
    end

    assign first  = (row == '0) && (col == '0);
    assign last   = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign border = (row == '0) || (row == RW'(IMG_H - 1))
                 || (col == '0) || (col == CW'(IMG_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            armed   <= 1'b0;
            pix_cnt <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (accept) begin
                pix_cnt <= (pix_cnt == PW'(NPIX - 1)) ? '0 : pix_cnt + 1'b1;
            end
            if (load) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.m_valid <= 1'b0;
            bus.m_mag   <= '0;
            bus.m_dir   <= DIR_0;
            bus.m_sof   <= 1'b0;
            bus.m_eof   <= 1'b0;
        end else if (load) begin
            bus.m_valid <= 1'b1;
            bus.m_mag   <= border ? '0 : mag;
            bus.m_dir   <= border ? DIR_0 : dir;
            bus.m_sof   <= first;
            bus.m_eof   <= last;
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream_gradient.sv
// Randomised stream bench for sobel_stream_gradient against a 2-D
// array reference of the Sobel, magnitude and direction rules.
module tb_sobel_stream_gradient;
    import canny_pkg::*;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int SH = 1;
    localparam int N  = W * H;

    typedef struct {
        int mag;
        int dir;
        int sof;
        int eof;
    } beat_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    checks   = 0;
    int    failures = 0;
    int    stim_q[$];
    beat_t exp_q[$];
    int    img[H][W];
    int    got_mag[N];
    int    got_dir[N];

    sobel_stream_gradient_if #(.DW(DW)) bus();

    sobel_stream_gradient #(
        .DW        (DW),
        .IMG_W     (W),
        .IMG_H     (H),
        .MAG_SHIFT (SH)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_frame();
        int gx, gy, ax, ay;
        beat_t b;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                stim_q.push_back(img[r][c]);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                b.sof = (r == 0 && c == 0) ? 1 : 0;
                b.eof = (r == H-1 && c == W-1) ? 1 : 0;
                b.mag = 0;
                b.dir = 0;
                if (r > 0 && r < H-1 && c > 0 && c < W-1) begin
                    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
                       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
                    gy = (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1])
                       - (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]);
                    ax = (gx < 0) ? -gx : gx;
                    ay = (gy < 0) ? -gy : gy;
                    b.mag = (ax + ay) >> SH;
                    if (b.mag > 255) b.mag = 255;
                    if (gx == 0 && gy == 0) b.dir = 0;
                    else if (5*ay < 2*ax) b.dir = 0;
                    else if (5*ax < 2*ay) b.dir = 2;
                    else if ((gx < 0) == (gy < 0)) b.dir = 1;
                    else b.dir = 3;
                end
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic drive(input int n, input int vpct);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            @(negedge clk);
            bus.s_valid = ($urandom_range(99) < vpct);
            bus.s_data  = DW'(stim_q[0]);
            #4;
            if (bus.s_valid && bus.s_ready) begin
                void'(stim_q.pop_front());
                sent++;
            end
            guard++;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        if (sent < n) chk("drive_timeout", sent, n);
    endtask

    task automatic collect(input int n, input int rpct);
        int got = 0;
        int guard = 0;
        bit held = 0;
        int hv = 0;
        int cur;
        beat_t e;
        while (got < n && guard < 40000) begin
            @(negedge clk);
            bus.m_ready = ($urandom_range(99) < rpct);
            #4;
            cur = int'({bus.m_mag, bus.m_dir, bus.m_sof, bus.m_eof});
            if (held) begin
                chk("stall_valid", int'(bus.m_valid), 1);
                chk("stall_data", cur, hv);
            end
            held = 0;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mag", int'(bus.m_mag), e.mag);
                    chk("dir", int'(bus.m_dir), e.dir);
                    chk("sof", int'(bus.m_sof), e.sof);
                    chk("eof", int'(bus.m_eof), e.eof);
                end
                got_mag[got % N] = int'(bus.m_mag);
                got_dir[got % N] = int'(bus.m_dir);
                got++;
            end else if (bus.m_valid) begin
                held = 1;
                hv   = cur;
            end
            guard++;
        end
        if (got < n) chk("collect_timeout", got, n);
        @(negedge clk);
        bus.m_ready = 1'b1;
    endtask

    task automatic run_frames(input int nf, input int vpct, input int rpct);
        fork
            drive(nf * N, vpct);
            collect(nf * N, rpct);
        join
        chk("exp_left", exp_q.size(), 0);
        #4;
        chk("idle_valid", int'(bus.m_valid), 0);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        #12;
        chk("rst_s_ready", int'(bus.s_ready), 0);
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_mag", int'(bus.m_mag), 0);
        chk("rst_m_dir", int'(bus.m_dir), 0);
        chk("rst_m_sof", int'(bus.m_sof), 0);
        chk("rst_m_eof", int'(bus.m_eof), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", int'(bus.s_ready), 1);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 100;
        model_frame();
        run_frames(1, 100, 100);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 0 : 80;
        model_frame();
        run_frames(1, 100, 100);
        chk("vstep_c3_mag", got_mag[2*W+3], 160);
        chk("vstep_c4_mag", got_mag[2*W+4], 160);
        chk("vstep_c3_dir", got_dir[2*W+3], 0);
        chk("vstep_c2_mag", got_mag[2*W+2], 0);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = (r < 3) ? 200 : 0;
        model_frame();
        run_frames(1, 100, 100);
        chk("hstep_r2_mag", got_mag[2*W+3], 255);
        chk("hstep_r3_mag", got_mag[3*W+3], 255);
        chk("hstep_r2_dir", got_dir[2*W+3], 2);

        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
            model_frame();
        end
        run_frames(3, 70, 50);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 10 * (r + c);
        model_frame();
        run_frames(1, 100, 100);
        chk("diag_mag", got_mag[2*W+3], 80);
        chk("diag_dir", got_dir[2*W+3], 3);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 10 * (r - c + 7);
        model_frame();
        run_frames(1, 100, 100);
        chk("adiag_mag", got_mag[2*W+3], 80);
        chk("adiag_dir", got_dir[2*W+3], 1);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
        model_frame();
        bus.m_ready = 1'b1;
        drive(30, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_m_valid", int'(bus.m_valid), 0);
        chk("abort_s_ready", int'(bus.s_ready), 0);
        chk("abort_m_mag", int'(bus.m_mag), 0);
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = $urandom_range(255);
        model_frame();
        run_frames(1, 70, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
